// File: rtl/fp_pkg.sv
// Shared fp16/fp32 field layout, class encoding and the fp16 operand decoder
// used by every multiply lane.
package fp_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP16_BIAS  = 15;
  localparam int FP32_BIAS  = 127;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;
  typedef enum logic [1:0] {RES_FIN, RES_ZERO, RES_INF, RES_NAN} res_kind_e;

  // man is always 1.xxx for finite nonzero operands; exp is unbiased
  typedef struct packed {
    logic                sign;
    fp_class_e           cls;
    logic signed [6:0]   exp;
    logic [10:0]         man;
  } fp16_dec_t;

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i < 11; i++)
      if (v[i]) lzc11 = 4'(10 - i);
  endfunction

  function automatic fp16_dec_t fp16_decode(input logic [15:0] x);
    fp16_dec_t                 d;
    logic [FP16_EXP_W-1:0]     e;
    logic [FP16_MAN_W-1:0]     m;
    logic [3:0]                lz;
    e      = x[FP16_MAN_W +: FP16_EXP_W];
    m      = x[FP16_MAN_W-1:0];
    lz     = lzc11({1'b0, m});
    d.sign = x[15];
    d.exp  = '0;
    d.man  = '0;
    if (e == '1) begin
      d.cls = (m == '0) ? CLS_INF : CLS_NAN;
    end else if (e == '0) begin
      if (m == '0) begin
        d.cls = CLS_ZERO;
      end else begin
        // shift by the 11-bit leading-zero count so the hidden bit lands at [10]
        d.cls = CLS_SUB;
        d.man = {1'b0, m} << lz;
        d.exp = 7'(1 - FP16_BIAS) - 7'(lz);
      end
    end else begin
      d.cls = CLS_NORM;
      d.man = {1'b1, m};
      d.exp = 7'(e) - 7'(FP16_BIAS);
    end
    return d;
  endfunction

endpackage

// File: rtl/fp16to32_mult_pipe_if.sv
// Operand/result stream bundle of the multi-lane fp16 x fp16 -> fp32 multiplier.
interface fp16to32_mult_pipe_if #(parameter int LANES = 4);
  logic                  in_valid;
  logic                  in_ready;
  logic [16*LANES-1:0]   in_a;
  logic [16*LANES-1:0]   in_b;
  logic                  in_neg;
  logic                  out_valid;
  logic                  out_ready;
  logic [32*LANES-1:0]   out_result;
  logic [LANES-1:0]      out_nan;
  logic [LANES-1:0]      out_inf;

  modport master (
    output in_valid, in_a, in_b, in_neg, out_ready,
    input  in_ready, out_valid, out_result, out_nan, out_inf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_neg, out_ready,
    output in_ready, out_valid, out_result, out_nan, out_inf
  );
endinterface

// File: rtl/fp16_lane_mul.sv
// One lane of the 3-stage fp16 x fp16 -> fp32 multiplier. Every stage loads on
// adv; only the final output registers are reset.
module fp16_lane_mul
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        neg,
  output logic [31:0] result,
  output logic        nan,
  output logic        inf
);

  fp16_dec_t              dec_a, dec_b;
  logic                   neg_s1;
  res_kind_e              kind_c, kind_s2;
  logic                   sign_s2;
  logic [21:0]            prod_c, prod_s2;
  logic [FP32_EXP_W-1:0]  exp_c, exp_s2, exp_n;
  logic [FP32_MAN_W-1:0]  frac_n;
  logic [31:0]            result_c;

  always_ff @(posedge clk) begin
    if (adv) begin
      dec_a  <= fp16_decode(a);
      dec_b  <= fp16_decode(b);
      neg_s1 <= neg;
    end
  end

  always_comb begin
    kind_c = RES_FIN;
    if (dec_a.cls == CLS_NAN || dec_b.cls == CLS_NAN ||
        (dec_a.cls == CLS_INF && dec_b.cls == CLS_ZERO) ||
        (dec_a.cls == CLS_ZERO && dec_b.cls == CLS_INF))
      kind_c = RES_NAN;
    else if (dec_a.cls == CLS_INF || dec_b.cls == CLS_INF)
      kind_c = RES_INF;
    else if (dec_a.cls == CLS_ZERO || dec_b.cls == CLS_ZERO)
      kind_c = RES_ZERO;
  end

  // true biased exponent lies in 79..157, so 8-bit wrap-around arithmetic is exact
  assign prod_c = 22'(dec_a.man) * 22'(dec_b.man);
  assign exp_c  = 8'(dec_a.exp) + 8'(dec_b.exp) + 8'(FP32_BIAS);

  always_ff @(posedge clk) begin
    if (adv) begin
      kind_s2 <= kind_c;
      sign_s2 <= dec_a.sign ^ dec_b.sign ^ neg_s1;
      prod_s2 <= prod_c;
      exp_s2  <= exp_c;
    end
  end

  always_comb begin
    exp_n  = exp_s2 + 8'({7'b0, prod_s2[21]});
    frac_n = prod_s2[21] ? {prod_s2[20:0], 2'b0} : {prod_s2[19:0], 3'b0};
    case (kind_s2)
      RES_NAN:  result_c = FP32_QNAN;
      RES_INF:  result_c = {sign_s2, {FP32_EXP_W{1'b1}}, {FP32_MAN_W{1'b0}}};
      RES_ZERO: result_c = {sign_s2, 31'b0};
      default:  result_c = {sign_s2, exp_n, frac_n};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      nan    <= 1'b0;
      inf    <= 1'b0;
    end else if (adv) begin
      result <= result_c;
      nan    <= (kind_s2 == RES_NAN);
      inf    <= (kind_s2 == RES_INF);
    end
  end

endmodule

// File: rtl/fp16to32_mult_pipe.sv
// LANES-wide fp16 x fp16 -> fp32 multiply pipeline: shared advance enable and
// valid chain here, per-lane datapath in fp16_lane_mul.
module fp16to32_mult_pipe #(
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp16to32_mult_pipe_if.slave   bus
);

  logic adv;
  logic vld_s1, vld_s2, vld_s3;

  // whole pipe stalls only when the output holds a result nobody takes
  assign adv           = !vld_s3 || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_s1 <= 1'b0;
      vld_s2 <= 1'b0;
      vld_s3 <= 1'b0;
    end else if (adv) begin
      vld_s1 <= bus.in_valid;
      vld_s2 <= vld_s1;
      vld_s3 <= vld_s2;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp16_lane_mul u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv    (adv),
      .a      (bus.in_a[16*i +: 16]),
      .b      (bus.in_b[16*i +: 16]),
      .neg    (bus.in_neg),
      .result (bus.out_result[32*i +: 32]),
      .nan    (bus.out_nan[i]),
      .inf    (bus.out_inf[i])
    );
  end

endmodule

// File: tb/tb_fp16to32_mult_pipe.sv
// Directed-vector bench for fp16to32_mult_pipe: hand-computed lane results,
// latency, stall hold, random backpressure and mid-stream reset.
module tb_fp16to32_mult_pipe;

  localparam int LANES = 4;

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic         neg;
    logic [127:0] r;
    logic [3:0]   nan;
    logic [3:0]   inf;
  } vec_t;

  typedef struct {
    logic [127:0] r;
    logic [3:0]   nan;
    logic [3:0]   inf;
    int           acc;
    bit           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  fp16to32_mult_pipe_if #(.LANES(LANES)) bus ();

  fp16to32_mult_pipe #(.LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  vec_t         vecs [4];
  exp_t         sb [$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;
  int           n_out = 0;
  int           cur_vec = 0;
  bit           lat_mode = 1'b1;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic drive(input int i);
    cur_vec    = i;
    bus.in_a   = vecs[i].a;
    bus.in_b   = vecs[i].b;
    bus.in_neg = vecs[i].neg;
  endtask

  task automatic drain(input bit rnd);
    for (int k = 0; k < 300 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    bus.out_ready = 1'b1;
  endtask

  // scoreboard: outputs sampled on the falling edge, transfers happen on the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        for (int l = 0; l < LANES; l++)
          chk($sformatf("hold_l%0d", l), bus.out_result[32*l +: 32], prev_res[32*l +: 32]);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res   = bus.out_result;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          for (int l = 0; l < LANES; l++)
            chk($sformatf("out%0d_l%0d", n_out, l), bus.out_result[32*l +: 32], e.r[32*l +: 32]);
          chk($sformatf("out%0d_nan", n_out), 32'(bus.out_nan), 32'(e.nan));
          chk($sformatf("out%0d_inf", n_out), 32'(bus.out_inf), 32'(e.inf));
          if (e.lat) chk($sformatf("out%0d_latency", n_out), 32'(cyc - e.acc), 32'd3);
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.r   = vecs[cur_vec].r;
        e.nan = vecs[cur_vec].nan;
        e.inf = vecs[cur_vec].inf;
        e.acc = cyc;
        e.lat = lat_mode;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err + 1);
    $fatal(1);
  end

  initial begin
    bit acc;
    int idx;

    // lane 0 is the least significant slice
    vecs[0] = '{a: 64'h0001_7BFF_3E00_3C00, b: 64'h0001_7BFF_3E00_3C00, neg: 1'b0,
                r: 128'h27800000_4F7FC004_40100000_3F800000, nan: 4'b0000, inf: 4'b0000};
    vecs[1] = '{a: 64'h4000_8000_FC00_7C00, b: 64'h4200_3C00_3C00_0000, neg: 1'b0,
                r: 128'h40C00000_80000000_FF800000_7FC00000, nan: 4'b0001, inf: 4'b0010};
    vecs[2] = '{a: 64'h7C00_0000_7E00_3C00, b: 64'h4000_3C00_3C00_BC00, neg: 1'b1,
                r: 128'hFF800000_80000000_7FC00000_3F800000, nan: 4'b0010, inf: 4'b1000};
    vecs[3] = '{a: 64'h03FF_C000_0200_0400, b: 64'h3C00_C000_4000_3C00, neg: 1'b0,
                r: 128'h387FC000_40800000_38800000_38800000, nan: 4'b0000, inf: 4'b0000};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_result_l0", bus.out_result[31:0], 32'd0);
    chk("rst_result_l3", bus.out_result[127:96], 32'd0);
    chk("rst_nan",       32'(bus.out_nan), 32'd0);
    chk("rst_inf",       32'(bus.out_inf), 32'd0);
    rst_n = 1'b1;

    // directed vectors back-to-back, out_ready held high
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(i);
      bus.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain(1'b0);
    chk("count_directed", 32'(n_out), 32'd4);

    // 10 back-to-back vectors with random backpressure
    lat_mode     = 1'b0;
    idx          = 0;
    drive(0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 400 && idx < 10; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 10) drive(idx % 4);
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    chk("bp_all_accepted", 32'(idx), 32'd10);
    bus.in_valid = 1'b0;
    drain(1'b1);
    chk("count_backpressure", 32'(n_out), 32'd14);

    // reset with three vectors in flight
    lat_mode      = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(i);
      bus.in_valid = 1'b1;
    end
    @(posedge clk); #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_result_l0", bus.out_result[31:0], 32'd0);
    chk("midrst_nan",       32'(bus.out_nan), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    drive(3);
    bus.in_valid = 1'b1;
    rst_n        = 1'b1;
    @(negedge clk);
    chk("post_rst_quiet0", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_quiet1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("post_rst_quiet2", 32'(bus.out_valid), 32'd0);
    drain(1'b0);
    repeat (4) @(posedge clk);
    chk("count_final", 32'(n_out), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fp16to32_mult_pipe.md
FP16TO32_MULT_PIPE -- requirements
Module: fp16to32_mult_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning number of independent fp16 x fp16 -> fp32 multiply lanes (1..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand vector valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port in_a  input  16*LANES  fp16 operand A, lane i at [16i+15:16i].
REQ-007 SHALL have port in_b  input  16*LANES  fp16 operand B, same packing.
REQ-008 SHALL have port in_neg  input  1  mode: 1 = negate every non-NaN product.
REQ-009 SHALL have port out_valid  output  1  result vector valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_result  output  32*LANES  fp32 products, lane i at [32i+31:32i].
REQ-012 SHALL have port out_nan  output  LANES  per-lane NaN result flag.
REQ-013 SHALL have port out_inf  output  LANES  per-lane infinity result flag.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 classify + subnormal normalise, S2 11x11 mantissa multiply + exponent sum, S3 normalise + pack.
REQ-015 SHALL use one advance enable: adv = !out_valid || out_ready; in_ready = adv; all stages move only when adv = 1.
REQ-016 SHALL capture a vector when in_valid && in_ready; each stage carries its own valid bit; bubbles propagate as invalid.
REQ-017 SHALL deliver a result exactly 3 cycles after acceptance when out_ready is held 1; sustained throughput one vector/cycle.
REQ-018 SHALL hold out_result, out_nan, out_inf, out_valid stable while out_valid && !out_ready; no vector lost or duplicated.
REQ-019 SHALL decode fp16 normal as 1.m x 2^(e-15); subnormal (e=0, m!=0) as mantissa left-shifted by leading-zero count lz, exponent -14-lz.
REQ-020 SHALL compute biased exponent = ea + eb + 127 (signed, 9 bits min); result always fp32 normal, hence exact, no rounding.
REQ-021 SHALL normalise 22-bit product p: if p[21], exp+1 and fraction = {p[20:0],2'b0}; else fraction = {p[19:0],3'b0}.
REQ-022 SHALL give sign = sa ^ sb ^ in_neg for zero, infinity and finite results.
REQ-023 SHALL output canonical NaN 0x7FC00000 (out_nan=1) if either input NaN, or infinity x zero; in_neg ignored.
REQ-024 SHALL output signed infinity (exp 0xFF, fraction 0, out_inf=1) for infinity x nonzero non-NaN.
REQ-025 SHALL output signed zero for zero x finite, including subnormal.
REQ-026 SHALL sample in_neg with the operands and pipeline it with them; changing it mid-stream affects only newly accepted vectors.
REQ-027 SHALL treat lanes independently; one lane special never alters another.

Reset
REQ-028 SHALL, while rst_n = 0, clear all stage valid bits asynchronously: out_valid = 0, in_ready = 1, out_result = 0, out_nan = 0, out_inf = 0.
REQ-029 SHALL discard all in-flight vectors on reset mid-operation; first acceptance possible on first rising edge with rst_n = 1.
REQ-030 SHALL leave datapath registers without reset except the output registers of REQ-028.

Structure
REQ-031 SHALL place FP16/FP32 field widths, biases (15, 127), canonical NaN constant and class encoding (zero, sub, norm, inf, nan) in shared package fp_pkg.
REQ-032 SHALL instantiate one sub-module fp16_lane_mul per lane holding the per-lane S1-S3 datapath; handshake and valid chain live in the top.

Verification
REQ-033 SHALL check basic: a=0x3C00, b=0x3C00, neg=0 -> 0x3F800000 after 3 cycles; a=0x3E00, b=0x3E00 -> 0x40100000.
REQ-034 SHALL check extremes: 0x7BFF x 0x7BFF -> 0x4F7FC004; 0x0001 x 0x0001 -> 0x27800000.
REQ-035 SHALL check specials: 0x7C00 x 0x0000 -> 0x7FC00000, nan=1; 0xFC00 x 0x3C00 -> 0xFF800000, inf=1; 0x8000 x 0x3C00 -> 0x80000000.
REQ-036 SHALL check mode: 0x3C00 x 0xBC00, neg=1 -> 0x3F800000; 0x7E00 x 0x3C00, neg=1 -> 0x7FC00000.
REQ-037 SHALL check backpressure: 10 back-to-back vectors, out_ready toggled random 50% -> all 10 results in order, outputs stable while stalled.
REQ-038 SHALL check reset: rst_n low with 3 vectors in flight -> out_valid 0 immediately, no stale result after release.
